// File: rtl/speed_ctl_pkg.sv
// Shared constants for the per-cycle speed scheduler: Disk II motor strobes,
// shadow regions, slow banks and control-register bit positions.
package speed_pkg;

    localparam logic [15:0] SLOT4_OFF = 16'hC0C8;
    localparam logic [15:0] SLOT4_ON  = 16'hC0C9;
    localparam logic [15:0] SLOT5_OFF = 16'hC0D8;
    localparam logic [15:0] SLOT5_ON  = 16'hC0D9;
    localparam logic [15:0] SLOT6_OFF = 16'hC0E8;
    localparam logic [15:0] SLOT6_ON  = 16'hC0E9;
    localparam logic [15:0] SLOT7_OFF = 16'hC0F8;
    localparam logic [15:0] SLOT7_ON  = 16'hC0F9;

    localparam logic [15:0] TEXT1_LO  = 16'h0400;
    localparam logic [15:0] TEXT1_HI  = 16'h07FF;
    localparam logic [15:0] HIRES1_LO = 16'h2000;
    localparam logic [15:0] HIRES1_HI = 16'h3FFF;
    localparam logic [15:0] HIRES2_LO = 16'h4000;
    localparam logic [15:0] HIRES2_HI = 16'h5FFF;
    localparam logic [15:0] SHR_LO    = 16'h2000;
    localparam logic [15:0] SHR_HI    = 16'h9FFF;

    localparam logic [7:0] BANK_00 = 8'h00;
    localparam logic [7:0] BANK_01 = 8'h01;
    localparam logic [7:0] BANK_E0 = 8'hE0;
    localparam logic [7:0] BANK_E1 = 8'hE1;

    localparam int unsigned CYA_FAST  = 7;
    localparam int unsigned SH_TEXT1  = 0;
    localparam int unsigned SH_HIRES1 = 1;
    localparam int unsigned SH_HIRES2 = 2;
    localparam int unsigned SH_SHR    = 3;

    // idx 0..3 maps to slots 4..7
    function automatic logic [15:0] motor_addr(input logic [1:0] idx, input logic on);
        case (idx)
            2'd0:    return on ? SLOT4_ON : SLOT4_OFF;
            2'd1:    return on ? SLOT5_ON : SLOT5_OFF;
            2'd2:    return on ? SLOT6_ON : SLOT6_OFF;
            default: return on ? SLOT7_ON : SLOT7_OFF;
        endcase
    endfunction

endpackage

// File: rtl/speed_ctl_if.sv
// CPU access, control registers and scheduler results exchanged with speed_ctl.
interface speed_ctl_if;
    logic        cpu_valid;
    logic        we;
    logic        IO;
    logic [7:0]  bank;
    logic [15:0] addr;
    logic [7:0]  cyareg;
    logic [7:0]  shadow;
    logic        slow;
    logic        stretch;
    logic [3:0]  motor_on;
    logic        refresh_pend;

    modport master (
        output cpu_valid, we, IO, bank, addr, cyareg, shadow,
        input  slow, stretch, motor_on, refresh_pend
    );

    modport slave (
        input  cpu_valid, we, IO, bank, addr, cyareg, shadow,
        output slow, stretch, motor_on, refresh_pend
    );
endinterface

// File: rtl/speed_ctl_motor_timer.sv
// Disk II motor-active flag for one slot, held on for HOLD PH0 cycles after
// the motor-off strobe.
module motor_timer #(
    parameter int unsigned   CW   = 20,
    parameter logic [CW-1:0] HOLD = CW'(1000)
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic on_hit,
    input  logic off_hit,
    output logic on
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            on  <= 1'b0;
        end else if (en) begin
            if (on_hit) begin
                on  <= 1'b1;
                cnt <= '0;
            end else if (off_hit && on) begin
                cnt <= HOLD;
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1))
                    on <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/speed_ctl.sv
// Per-cycle fast/slow scheduler feeding clock_divider: decides slow and the
// refresh stretch at each PH0 cycle start.
module speed_ctl
    import speed_pkg::*;
#(
    parameter int unsigned   CW               = 20,
    parameter logic [CW-1:0] MOTOR_HOLD       = CW'(1000),
    parameter logic [7:0]    REFRESH_INTERVAL = 8'd36
) (
    input  logic       clk_14M,
    input  logic       reset,
    input  logic       ph0_en,
    speed_ctl_if.slave bus
);

    logic       access_slow;
    logic       next_slow;
    logic       shadow_hit;
    logic [3:0] motor_on;
    logic [7:0] refresh_cnt;
    logic       slow;
    logic       stretch;
    logic       refresh_pend;
    logic       unused_bits;

    assign unused_bits = ^{bus.cyareg[6:4], bus.shadow[7:4]};

    always_comb begin
        shadow_hit  = 1'b0;
        access_slow = 1'b0;
        if (bus.addr >= TEXT1_LO && bus.addr <= TEXT1_HI && !bus.shadow[SH_TEXT1])
            shadow_hit = 1'b1;
        if (bus.addr >= HIRES1_LO && bus.addr <= HIRES1_HI && !bus.shadow[SH_HIRES1])
            shadow_hit = 1'b1;
        if (bus.addr >= HIRES2_LO && bus.addr <= HIRES2_HI && !bus.shadow[SH_HIRES2])
            shadow_hit = 1'b1;
        if (bus.addr >= SHR_LO && bus.addr <= SHR_HI && !bus.shadow[SH_SHR])
            shadow_hit = 1'b1;
        if (bus.cpu_valid) begin
            if (bus.IO || bus.bank == BANK_E0 || bus.bank == BANK_E1)
                access_slow = 1'b1;
            if (bus.we && (bus.bank == BANK_00 || bus.bank == BANK_01) && shadow_hit)
                access_slow = 1'b1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_motor
        logic on_hit;
        logic off_hit;
        assign on_hit  = bus.cpu_valid && bus.IO && bus.addr == motor_addr(2'(i), 1'b1);
        assign off_hit = bus.cpu_valid && bus.IO && bus.addr == motor_addr(2'(i), 1'b0);

        motor_timer #(.CW(CW), .HOLD(MOTOR_HOLD)) u_timer (
            .clk     (clk_14M),
            .rst     (reset),
            .en      (ph0_en),
            .on_hit  (on_hit),
            .off_hit (off_hit),
            .on      (motor_on[i])
        );
    end

    // motor_on here is the value before this PH0's motor update
    assign next_slow = !bus.cyareg[CYA_FAST] || (|(motor_on & bus.cyareg[3:0])) || access_slow;

    always_ff @(posedge clk_14M) begin
        if (reset) begin
            slow         <= 1'b1;
            stretch      <= 1'b0;
            refresh_pend <= 1'b0;
            refresh_cnt  <= '0;
        end else if (ph0_en) begin
            slow    <= next_slow;
            stretch <= !next_slow && refresh_pend;
            if (!next_slow) begin
                if (refresh_cnt == REFRESH_INTERVAL - 8'd1) begin
                    refresh_cnt  <= '0;
                    refresh_pend <= 1'b1;
                end else begin
                    refresh_cnt <= refresh_cnt + 8'd1;
                    if (refresh_pend)
                        refresh_pend <= 1'b0;
                end
            end
        end
    end

    assign bus.slow         = slow;
    assign bus.stretch      = stretch;
    assign bus.motor_on     = motor_on;
    assign bus.refresh_pend = refresh_pend;

endmodule

// File: tb/tb_speed_ctl.sv
// Randomised self-checking bench for speed_ctl against a behavioural model of
// the speed-selection, motor-hold and refresh rules.
module tb_speed_ctl;

    localparam int HOLD     = 1000;
    localparam int INTERVAL = 36;

    logic clk_14M = 1'b0;
    logic reset   = 1'b1;
    logic ph0_en  = 1'b0;

    speed_ctl_if bus();

    speed_ctl #(.CW(20), .MOTOR_HOLD(20'd1000), .REFRESH_INTERVAL(8'd36)) dut (
        .clk_14M (clk_14M),
        .reset   (reset),
        .ph0_en  (ph0_en),
        .bus     (bus)
    );

    always #5 clk_14M = ~clk_14M;

    int checks = 0;
    int passed = 0;

    bit m_on [4];
    int m_rem [4];
    bit owed;
    int n_fast;
    bit e_slow;
    bit e_stretch;

    function automatic logic [6:0] got_vec();
        return {bus.slow, bus.stretch, bus.motor_on, bus.refresh_pend};
    endfunction

    function automatic logic [3:0] model_motor();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_on[i];
        return v;
    endfunction

    function automatic logic [6:0] exp_vec();
        return {e_slow, e_stretch, model_motor(), owed};
    endfunction

    function automatic bit in_rng(input logic [15:0] a, input int lo, input int hi);
        return int'(a) >= lo && int'(a) <= hi;
    endfunction

    function automatic bit ref_access_slow();
        bit region;
        if (!bus.cpu_valid) return 1'b0;
        if (bus.IO) return 1'b1;
        if (bus.bank == 8'hE0 || bus.bank == 8'hE1) return 1'b1;
        region = (in_rng(bus.addr, 'h0400, 'h07FF) && !bus.shadow[0])
              || (in_rng(bus.addr, 'h2000, 'h3FFF) && !bus.shadow[1])
              || (in_rng(bus.addr, 'h4000, 'h5FFF) && !bus.shadow[2])
              || (in_rng(bus.addr, 'h2000, 'h9FFF) && !bus.shadow[3]);
        return bus.we && bus.bank <= 8'h01 && region;
    endfunction

    task automatic model_reset();
        e_slow = 1'b1; e_stretch = 1'b0; owed = 1'b0; n_fast = 0;
        for (int i = 0; i < 4; i++) begin m_on[i] = 1'b0; m_rem[i] = 0; end
    endtask

    task automatic drive(input bit v, input bit w, input bit io, input logic [7:0] b, input logic [15:0] a);
        bus.cpu_valid = v; bus.we = w; bus.IO = io; bus.bank = b; bus.addr = a;
    endtask

    // One PH0 cycle with the inputs currently on the bus; returns 1 time unit after the edge.
    task automatic cycle();
        bit acc;
        bit hit_on;
        bit hit_off;
        logic [15:0] a_on;
        acc = ref_access_slow();
        e_slow = !bus.cyareg[7] || ((model_motor() & bus.cyareg[3:0]) != 4'b0) || acc;
        for (int i = 0; i < 4; i++) begin
            a_on    = 16'hC0C9 + 16'(i * 16);
            hit_on  = bus.cpu_valid && bus.IO && bus.addr == a_on;
            hit_off = bus.cpu_valid && bus.IO && bus.addr == a_on - 16'd1;
            if (hit_on) begin
                m_on[i] = 1'b1; m_rem[i] = 0;
            end else if (hit_off && m_on[i]) begin
                m_rem[i] = HOLD;
            end else if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_on[i] = 1'b0;
            end
        end
        e_stretch = 1'b0;
        if (!e_slow) begin
            e_stretch = owed;
            owed = 1'b0;
            n_fast++;
            if (n_fast % INTERVAL == 0) owed = 1'b1;
        end
        ph0_en = 1'b1;
        @(posedge clk_14M);
        #1;
        ph0_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        bus.cyareg = 8'h80; bus.shadow = 8'hFF;
        repeat (3) @(posedge clk_14M);
        #1;
        model_reset();
        checks++;
        if (got_vec() !== 7'b1_0_0000_0)
            $display("FAIL reset_state: got %b want %b", got_vec(), 7'b1_0_0000_0);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_refresh();
        int stretches = 0;
        bus.cyareg = 8'h80; bus.shadow = 8'hFF;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        for (int k = 1; k <= 2 * INTERVAL + 2; k++) begin
            cycle();
            checks++;
            if (got_vec() !== exp_vec())
                $display("FAIL refresh_cycle%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
            if (bus.stretch === 1'b1) stretches++;
        end
        checks++;
        if (stretches !== 2)
            $display("FAIL refresh_count: got %0d want %0d", stretches, 2);
        else passed++;
    endtask

    task automatic test_motor();
        bus.cyareg = 8'hFF;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E9);
        cycle();
        checks++;
        if ({bus.slow, bus.motor_on} !== 5'b1_0100)
            $display("FAIL motor_on_access: got %b want %b", {bus.slow, bus.motor_on}, 5'b1_0100);
        else passed++;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) bus.cyareg = 8'h80;
            cycle();
            checks++;
            if (got_vec() !== exp_vec() || bus.slow !== (k < 10) || bus.motor_on !== 4'b0100)
                $display("FAIL motor_gate%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_shadow();
        logic [7:0]  sh [5]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        logic        wr [5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0]  bk [5]  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hE1};
        logic [15:0] ad [5]  = '{16'h0400, 16'h0800, 16'h0400, 16'h0400, 16'h1234};
        logic        want [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.cyareg = 8'h80;
        for (int k = 0; k < 5; k++) begin
            bus.shadow = sh[k];
            drive(1'b1, wr[k], 1'b0, bk[k], ad[k]);
            cycle();
            checks++;
            if (got_vec() !== exp_vec() || bus.slow !== want[k])
                $display("FAIL shadow%0d: got %b want %b slow %b", k, got_vec(), exp_vec(), want[k]);
            else passed++;
        end
        bus.shadow = 8'hFF;
    endtask

    task automatic test_refresh_deferral();
        int guard = 0;
        int stretches = 0;
        bus.cyareg = 8'h80; bus.shadow = 8'hFF;
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        do begin
            cycle();
            guard++;
        end while (!owed && guard < 2 * INTERVAL);
        checks++;
        if (bus.refresh_pend !== 1'b1)
            $display("FAIL defer_pend: got %b want %b", bus.refresh_pend, 1'b1);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC000 + 16'(k));
            cycle();
            checks++;
            if (got_vec() !== exp_vec() || {bus.slow, bus.stretch, bus.refresh_pend} !== 3'b101)
                $display("FAIL defer_io%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
        end
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (bus.stretch === 1'b1) stretches++;
            checks++;
            if (got_vec() !== exp_vec() || bus.stretch !== (k == 0))
                $display("FAIL defer_fast%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (stretches !== 1)
            $display("FAIL defer_single: got %0d want %0d", stretches, 1);
        else passed++;
    endtask

    task automatic test_holdoff();
        bus.cyareg = 8'hFF;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E9); cycle();
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E8); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        for (int k = 1; k <= HOLD + 1; k++) begin
            cycle();
            checks++;
            if (got_vec() !== exp_vec() || bus.slow !== (k <= HOLD))
                $display("FAIL holdoff%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (bus.motor_on !== 4'b0000)
            $display("FAIL holdoff_expired: got %b want %b", bus.motor_on, 4'b0000);
        else passed++;
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E9); cycle();
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E8); cycle();
        for (int k = 1; k <= 1600; k++) begin
            if (k == 500) drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E9);
            else          drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
            cycle();
            checks++;
            if (got_vec() !== exp_vec() || bus.motor_on !== 4'b0100)
                $display("FAIL holdoff_cancel%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b1, 8'h00, 16'hC0E8); cycle();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 16'h1000);
        bus.cyareg = 8'h80;
        repeat (300) cycle();
        reset = 1'b1; ph0_en = 1'b1;
        @(posedge clk_14M);
        #1;
        reset = 1'b0; ph0_en = 1'b0;
        model_reset();
        checks++;
        if (got_vec() !== 7'b1_0_0000_0)
            $display("FAIL reset_mid: got %b want %b", got_vec(), 7'b1_0_0000_0);
        else passed++;
        bus.cyareg = 8'hFF;
        cycle();
        checks++;
        if (got_vec() !== exp_vec() || bus.motor_on !== 4'b0000)
            $display("FAIL reset_mid_after: got %b want %b", got_vec(), exp_vec());
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] banks [5] = '{8'h00, 8'h01, 8'hE0, 8'hE1, 8'h00};
        logic [15:0] a;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 5))
                0:       a = 16'hC0C8 + 16'($urandom_range(0, 3) * 16) + 16'($urandom_range(0, 1));
                1:       a = 16'h0400 + 16'($urandom_range(0, 'h3FF));
                2:       a = 16'h2000 + 16'($urandom_range(0, 'h7FFF));
                3:       a = 16'($urandom_range(0, 1) ? 'h07FF : 'h9FFF) + 16'($urandom_range(0, 1));
                default: a = 16'($urandom);
            endcase
            bus.cyareg = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {1'b1, 7'($urandom)};
            bus.shadow = 8'($urandom);
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 4) ? 8'($urandom) : banks[$urandom_range(0, 3)], a);
            cycle();
            checks++;
            if (got_vec() !== exp_vec())
                $display("FAIL random%0d: got %b want %b", k, got_vec(), exp_vec());
            else passed++;
            repeat ($urandom_range(0, 2)) begin
                drive(1'b1, 1'($urandom), 1'b1, 8'($urandom), 16'hC0C9 + 16'($urandom_range(0, 3) * 16));
                bus.cyareg = 8'($urandom);
                @(posedge clk_14M);
                #1;
                checks++;
                if (got_vec() !== exp_vec())
                    $display("FAIL hold%0d: got %b want %b", k, got_vec(), exp_vec());
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_refresh();
        test_motor();
        test_shadow();
        test_refresh_deferral();
        test_holdoff();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/speed_ctl.md
Name: speed_ctl

Overview:
- Per-cycle speed scheduler in front of clock_divider.
- On each CPU cycle start, decides whether the cycle runs fast or synchronises to the 1 MHz side.
  - Drives clock_divider `slow` and `stretch`.
  - Decision sources: CYAREG, the shadow register, the access address, Disk II motor state per slot (4-7), and periodic fast-RAM refresh.
- Sits between CPU address decode and clock_divider, in the clk_14M domain.

Parameters:
- MOTOR_HOLD, 20'd1000: PH0 cycles a slot stays "motor active" after its motor-off access.
- REFRESH_INTERVAL, 8'd36: fast cycles between refresh stretches.
- CW, 20: motor hold counter width.

Ports:
- clk_14M  in  1  system clock (14.318 MHz).
- reset  in  1  synchronous, active-high.
- ph0_en  in  1  cycle-start enable from clock_divider.
- cpu_valid  in  1  CPU presents a valid access this cycle.
- we  in  1  access is a write.
- IO  in  1  access decodes to the C0xx I/O page.
- bank  in  8  CPU bank.
- addr  in  16  CPU address.
- cyareg  in  8  bit7 = fast enable; bits3:0 = motor-detect enable, slots 7..4.
- shadow  in  8  shadow inhibit bits (1 = inhibit):
  - bit0: text page 1, 0400-07FF.
  - bit1: hires 1, 2000-3FFF.
  - bit2: hires 2, 4000-5FFF.
  - bit3: SHR, 2000-9FFF.
- slow  out  1  to clock_divider.slow.
- stretch  out  1  to clock_divider.stretch.
- motor_on  out  4  per-slot motor-active flags, slots 7..4.
- refresh_pend  out  1  a refresh stretch is owed.

Behaviour:
- One clock, synchronous active-high reset. All state updates only on `clk_14M` edges with `ph0_en`=1, except reset.
- Reset values: slow=1, stretch=0, motor_on=0, refresh_pend=0, all counters 0.
- Motor tracking, slot s = 4..7:
  - Address C0(8+s)9 with IO=1 and cpu_valid=1 is an ON access; C0(8+s)8 is an OFF access. Examples: slot 6 = C0E9/C0E8, slot 4 = C0C9/C0C8.
  - ON access: motor_on[s-4]=1, hold counter cleared.
  - OFF access while on: hold counter loads MOTOR_HOLD. Counter decrements each PH0 cycle; motor_on clears on the PH0 where it reaches 0.
  - ON access during holdoff cancels the countdown; motor stays on.
  - OFF access while already off: no effect.
  - Tracking runs regardless of cyareg; cyareg only gates the slow contribution.
- Access-slow term (combinational from the sampled access):
  - Any one of these makes it 1: IO=1; bank E0 or E1; a write to bank 00 or 01 inside a shadowed region whose inhibit bit is 0.
  - Region bounds are inclusive.
  - No cpu_valid means access-slow = 0.
- Slow decision, registered at ph0_en: slow <= ~cyareg[7] | (|(motor_on & cyareg[3:0])) | access_slow.
  - Latency: one clk_14M after the ph0_en sample.
  - Holds until the next ph0_en.
  - The motor_on used is the pre-update value. The access that turns a motor on is itself slow through the IO term.
- Refresh scheduling:
  - An 8-bit counter counts PH0 cycles whose decided slow=0.
  - On reaching REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_pend.
  - At a ph0_en that decides slow=0 with refresh_pend=1: stretch <= 1 for that cycle, refresh_pend <= 0.
  - A slow cycle never carries stretch; the refresh stays pending, no loss and no double count.
  - A new interval expiry while already pending does not queue a second refresh.
  - stretch otherwise <= 0 at each ph0_en.
- Reset asserted mid-cycle: all state returns to reset values on the next edge. The motor state is discarded.

Decomposition:
- Shared package speed_pkg: slot motor address constants (C0C8..C0F9), shadow region bounds, bank constants E0/E1, bit indices of cyareg and shadow.
- Sub-module motor_timer (CW-bit hold counter plus on flag), instantiated four times.

Test Plan:
- Reset, cyareg=80, shadow=FF, reads of 00:1000 -> slow=0 every cycle; stretch=1 on exactly every 36th PH0; 36 cycles later refresh_pend pulses again.
- cyareg=FF, access C0E9 -> that cycle slow=1; motor_on=4'b0100; later reads of 00:1000 stay slow=1; with cyareg=80 the same reads are slow=0 while motor_on stays 4'b0100.
- From motor on, access C0E8 -> slow remains 1 for MOTOR_HOLD (1000) PH0 cycles, then motor_on=0 and slow=0 on the next cycle; a C0E9 at cycle 500 of the holdoff keeps motor_on=1 indefinitely.
- shadow=00, write 00:0400 -> slow=1; write 00:0800 -> slow=0; read 00:0400 -> slow=0; shadow=01, write 00:0400 -> slow=0; write E1:1234 -> slow=1.
- refresh_pend=1 and the next 3 cycles are IO reads -> stretch=0 for those 3; stretch=1 on the first following fast cycle; only one stretch issued.
- Reset asserted during motor holdoff -> next cycle motor_on=0, slow=1, stretch=0, refresh_pend=0.
